exe_stage: RTL and testbench

//  Execute stage of the 5-stage LoongArch32 pipeline, between ID and MEM.

---
 rtl/exe_stage_pkg.sv | 48 ++++
 rtl/exe_stage_alu.sv | 34 +++
 rtl/exe_stage.sv | 91 +++++++++
 tb/tb_exe_stage.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exe_stage_pkg.sv
// Shared types for the execute stage: bus widths, ALU opcodes and the packed
// layouts of the ID->EX and EX->MEM buses.
package exe_stage_pkg;

   localparam int DS_TO_ES_BUS_W = 142;
   localparam int ES_TO_MS_BUS_W = 71;

   typedef enum logic [3:0] {
      ALU_ADD = 4'd0,
      ALU_SUB = 4'd1,
      ALU_SLT = 4'd2,
      ALU_AND = 4'd3,
      ALU_OR  = 4'd4,
      ALU_XOR = 4'd5,
      ALU_SLL = 4'd6,
      ALU_SRL = 4'd7,
      ALU_MUL = 4'd8,
      ALU_OP2 = 4'd9
   } alu_op_e;

   // Field order is MSB..LSB of the flat bus.
   typedef struct packed {
      logic        res_from_mem;
      logic        mem_we;
      logic        gr_we;
      logic [4:0]  dest;
      logic        src2_is_imm;
      logic        src1_is_pc;
      alu_op_e     alu_op;
      logic [31:0] imm;
      logic [31:0] rkd_val;
      logic [31:0] rj_val;
      logic [31:0] pc;
   } ds_to_es_t;

   typedef struct packed {
      logic        res_from_mem;
      logic        gr_we;
      logic [4:0]  dest;
      logic [31:0] alu_result;
      logic [31:0] pc;
   } es_to_ms_t;

   function automatic logic is_mem_op(input ds_to_es_t b);
      return b.res_from_mem | b.mem_we;
   endfunction

endpackage

// File: rtl/exe_stage_alu.sv
// Combinational ALU for the execute stage; unknown opcodes produce zero.
module exe_stage_alu
   import exe_stage_pkg::*;
(
   input  logic [31:0] op1,
   input  logic [31:0] op2,
   input  alu_op_e     alu_op,
   output logic [31:0] alu_output
);

   logic [31:0] mul_lo;
   logic        lt_signed;

   assign mul_lo    = op1 * op2;
   assign lt_signed = $signed(op1) < $signed(op2);

   always_comb begin
      alu_output = 32'd0;
      case (alu_op)
         ALU_ADD: alu_output = op1 + op2;
         ALU_SUB: alu_output = op1 - op2;
         ALU_SLT: alu_output = {31'd0, lt_signed};
         ALU_AND: alu_output = op1 & op2;
         ALU_OR:  alu_output = op1 | op2;
         ALU_XOR: alu_output = op1 ^ op2;
         ALU_SLL: alu_output = op1 << op2[4:0];
         ALU_SRL: alu_output = op1 >> op2[4:0];
         ALU_MUL: alu_output = mul_lo;
         ALU_OP2: alu_output = op2;
         default: alu_output = 32'd0;
      endcase
   end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: ID->EX pipeline register with valid/allowin handshake,
// operand selection, ALU, data-SRAM request and the EX bypass bus to ID.
module exe_stage
   import exe_stage_pkg::*;
(
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      ds_to_es_valid,
   output logic                      es_allowin,
   input  logic [DS_TO_ES_BUS_W-1:0] ds_to_es_bus,
   input  logic                      ms_allowin,
   output logic                      es_to_ms_valid,
   output logic [ES_TO_MS_BUS_W-1:0] es_to_ms_bus,
   output logic                      es_fwd_we,
   output logic [4:0]                es_fwd_dest,
   output logic [31:0]               es_fwd_data,
   output logic                      es_fwd_is_load,
   output logic                      data_sram_en,
   output logic [3:0]                data_sram_we,
   output logic [31:0]               data_sram_addr,
   output logic [31:0]               data_sram_wdata
);

   logic        es_valid_reg;
   ds_to_es_t   es_bus_reg;
   logic        es_ready_go;
   logic [31:0] op1;
   logic [31:0] op2;
   logic [31:0] alu_result;
   logic        mem_go;
   es_to_ms_t   ms_pkt;

   assign es_ready_go = 1'b1;
   assign es_allowin  = ~es_valid_reg | (es_ready_go & ms_allowin);

   always_ff @(posedge clk) begin
      if (reset) begin
         es_valid_reg <= 1'b0;
      end else if (es_allowin) begin
         es_valid_reg <= ds_to_es_valid;
      end
   end

   // Payload carries no reset: it is meaningless while es_valid_reg is low.
   always_ff @(posedge clk) begin
      if (ds_to_es_valid & es_allowin) begin
         es_bus_reg <= ds_to_es_t'(ds_to_es_bus);
      end
   end

   assign op1 = es_bus_reg.src1_is_pc  ? es_bus_reg.pc  : es_bus_reg.rj_val;
   assign op2 = es_bus_reg.src2_is_imm ? es_bus_reg.imm : es_bus_reg.rkd_val;

   exe_stage_alu alu_ (
      .op1        (op1),
      .op2        (op2),
      .alu_op     (es_bus_reg.alu_op),
      .alu_output (alu_result)
   );

   assign es_to_ms_valid = es_valid_reg & es_ready_go;

   always_comb begin
      ms_pkt              = '0;
      ms_pkt.res_from_mem = es_bus_reg.res_from_mem;
      ms_pkt.gr_we        = es_bus_reg.gr_we;
      ms_pkt.dest         = es_bus_reg.dest;
      ms_pkt.alu_result   = alu_result;
      ms_pkt.pc           = es_bus_reg.pc;
   end
   assign es_to_ms_bus = ms_pkt;

   // Issue the SRAM request only on the cycle the instruction leaves for MEM,
   // so a stalled access is never strobed twice.
   assign mem_go          = es_valid_reg & ms_allowin;
   assign data_sram_en    = mem_go & is_mem_op(es_bus_reg);
   assign data_sram_addr  = alu_result;
   assign data_sram_wdata = es_bus_reg.rkd_val;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_byte_we
         assign data_sram_we[gi] = mem_go & es_bus_reg.mem_we;
      end
   endgenerate

   assign es_fwd_we      = es_valid_reg & es_bus_reg.gr_we & (es_bus_reg.dest != 5'd0);
   assign es_fwd_dest    = es_valid_reg ? es_bus_reg.dest : 5'd0;
   assign es_fwd_data    = es_valid_reg ? alu_result : 32'd0;
   assign es_fwd_is_load = es_valid_reg & es_bus_reg.res_from_mem;

endmodule

// File: tb/tb_exe_stage.sv
// Scoreboard bench for exe_stage: directed scenarios followed by random traffic,
// all expectations produced by a behavioural model of the stage.
module tb_exe_stage;
   import exe_stage_pkg::*;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          ds_to_es_valid = 1'b0;
   logic          es_allowin;
   logic [141:0]  ds_to_es_bus = '0;
   logic          ms_allowin = 1'b1;
   logic          es_to_ms_valid;
   logic [70:0]   es_to_ms_bus;
   logic          es_fwd_we;
   logic [4:0]    es_fwd_dest;
   logic [31:0]   es_fwd_data;
   logic          es_fwd_is_load;
   logic          data_sram_en;
   logic [3:0]    data_sram_we;
   logic [31:0]   data_sram_addr;
   logic [31:0]   data_sram_wdata;

   always #5 clk = ~clk;

   exe_stage dut (
      .clk             (clk),
      .reset           (reset),
      .ds_to_es_valid  (ds_to_es_valid),
      .es_allowin      (es_allowin),
      .ds_to_es_bus    (ds_to_es_bus),
      .ms_allowin      (ms_allowin),
      .es_to_ms_valid  (es_to_ms_valid),
      .es_to_ms_bus    (es_to_ms_bus),
      .es_fwd_we       (es_fwd_we),
      .es_fwd_dest     (es_fwd_dest),
      .es_fwd_data     (es_fwd_data),
      .es_fwd_is_load  (es_fwd_is_load),
      .data_sram_en    (data_sram_en),
      .data_sram_we    (data_sram_we),
      .data_sram_addr  (data_sram_addr),
      .data_sram_wdata (data_sram_wdata)
   );

   typedef struct {
      logic [70:0] bus;
      logic        mem;
      logic        st;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        fwd_we;
      logic [4:0]  dest;
      logic [31:0] data;
      logic        ld;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   logic model_valid = 1'b0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", name, act, req);
      end
   endtask

   function automatic logic [141:0] mk_bus(input logic rfm, input logic mw, input logic gw,
                                           input logic [4:0] d, input logic s2i, input logic s1p,
                                           input logic [3:0] op, input logic [31:0] imm,
                                           input logic [31:0] rkd, input logic [31:0] rj,
                                           input logic [31:0] pc);
      return {rfm, mw, gw, d, s2i, s1p, op, imm, rkd, rj, pc};
   endfunction

   function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      longint unsigned p;
      case (op)
         ALU_ADD: return a + b;
         ALU_SUB: return a - b;
         ALU_SLT: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         ALU_AND: return a & b;
         ALU_OR:  return a | b;
         ALU_XOR: return a ^ b;
         ALU_SLL: return a << (b % 32);
         ALU_SRL: return a >> (b % 32);
         ALU_MUL: begin
            p = longint'(a) * longint'(b);
            return 32'(p);
         end
         ALU_OP2: return b;
         default: return 32'd0;
      endcase
   endfunction

   function automatic exp_t model(input logic [141:0] b);
      exp_t        e;
      logic        rfm, mw, gw, s2i, s1p;
      logic [4:0]  d;
      logic [3:0]  op;
      logic [31:0] imm, rkd, rj, pc, res;
      {rfm, mw, gw, d, s2i, s1p, op, imm, rkd, rj, pc} = b;
      res      = ref_alu(op, s1p ? pc : rj, s2i ? imm : rkd);
      e.bus    = {rfm, gw, d, res, pc};
      e.mem    = rfm | mw;
      e.st     = mw;
      e.addr   = res;
      e.wdata  = rkd;
      e.fwd_we = gw && (d != 5'd0);
      e.dest   = d;
      e.data   = res;
      e.ld     = rfm;
      return e;
   endfunction

   function automatic logic [141:0] rand_bus();
      int         kind;
      logic       rfm, mw, gw;
      kind = int'($urandom_range(0, 3));
      rfm  = (kind == 0);
      mw   = (kind == 1);
      gw   = (kind == 0) ? 1'b1 : ((kind == 1) ? 1'b0 : 1'($urandom));
      return mk_bus(rfm, mw, gw, 5'($urandom), 1'($urandom), 1'($urandom),
                    4'($urandom_range(0, 9)), $urandom, $urandom, $urandom, $urandom);
   endfunction

   // One clock of stimulus; the bench tracks stage occupancy to know when ID is accepted.
   task automatic cycle(input logic dv, input logic [141:0] b, input logic ma);
      logic acc, nv;
      ds_to_es_valid = dv;
      ds_to_es_bus   = b;
      ms_allowin     = ma;
      @(negedge clk);
      acc = !model_valid || ma;
      chk("es_allowin", 128'(es_allowin), 128'(acc));
      chk("es_to_ms_valid", 128'(es_to_ms_valid), 128'(model_valid));
      nv = model_valid;
      if (acc) begin
         if (dv) exp_q.push_back(model(b));
         nv = dv;
      end
      @(posedge clk);
      #1;
      model_valid = nv;
   endtask

   task automatic do_reset(input int n);
      reset          = 1'b1;
      ds_to_es_valid = 1'b1;
      ds_to_es_bus   = mk_bus(0, 1, 1, 5'd2, 0, 0, ALU_ADD, 0, 32'd1, 32'd1, 32'h100);
      ms_allowin     = 1'b1;
      repeat (n) @(posedge clk);
      #1;
      exp_q.delete();
      model_valid = 1'b0;
      chk("rst_es_to_ms_valid", 128'(es_to_ms_valid), 128'(0));
      chk("rst_sram_en", 128'(data_sram_en), 128'(0));
      reset          = 1'b0;
      ds_to_es_valid = 1'b0;
      #1;
      chk("rst_es_allowin", 128'(es_allowin), 128'(1));
      chk("rst_sram_en_after", 128'(data_sram_en), 128'(0));
   endtask

   // Monitor: compares whatever EX presents against the head of the scoreboard.
   always @(negedge clk) begin
      exp_t e;
      if (reset === 1'b0) begin
         if (es_to_ms_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_valid: actual 1 required 0");
            end else begin
               e = exp_q[0];
               chk("mon_bus", 128'(es_to_ms_bus), 128'(e.bus));
               chk("mon_fwd_we", 128'(es_fwd_we), 128'(e.fwd_we));
               chk("mon_fwd_dest", 128'(es_fwd_dest), 128'(e.dest));
               chk("mon_fwd_data", 128'(es_fwd_data), 128'(e.data));
               chk("mon_fwd_is_load", 128'(es_fwd_is_load), 128'(e.ld));
               if (ms_allowin === 1'b1) begin
                  chk("mon_sram_en", 128'(data_sram_en), 128'(e.mem));
                  chk("mon_sram_we", 128'(data_sram_we), 128'({4{e.st}}));
                  if (e.mem) begin
                     chk("mon_sram_addr", 128'(data_sram_addr), 128'(e.addr));
                     chk("mon_sram_wdata", 128'(data_sram_wdata), 128'(e.wdata));
                  end
                  void'(exp_q.pop_front());
               end else begin
                  chk("mon_stall_sram_en", 128'(data_sram_en), 128'(0));
                  chk("mon_stall_sram_we", 128'(data_sram_we), 128'(0));
               end
            end
         end else begin
            chk("idle_sram_en", 128'(data_sram_en), 128'(0));
            chk("idle_sram_we", 128'(data_sram_we), 128'(0));
            chk("idle_fwd_we", 128'(es_fwd_we), 128'(0));
            chk("idle_fwd_is_load", 128'(es_fwd_is_load), 128'(0));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

   initial begin
      logic [70:0] snap;
      do_reset(2);

      // add.w r3 = 5 + 7
      cycle(1, mk_bus(0, 0, 1, 5'd3, 0, 0, ALU_ADD, 0, 32'd7, 32'd5, 32'h1C00_0000), 1);
      chk("add_valid", 128'(es_to_ms_valid), 128'(1));
      chk("add_result", 128'(es_to_ms_bus[63:32]), 128'(12));
      chk("add_fwd_we", 128'(es_fwd_we), 128'(1));
      chk("add_fwd_dest", 128'(es_fwd_dest), 128'(3));
      chk("add_fwd_data", 128'(es_fwd_data), 128'(12));

      // st.w: address 0x1000 + 8
      cycle(1, mk_bus(0, 1, 0, 5'd0, 1, 0, ALU_ADD, 32'd8, 32'hDEAD_BEEF, 32'h1000, 32'h1C00_0004), 1);
      chk("st_en", 128'(data_sram_en), 128'(1));
      chk("st_we", 128'(data_sram_we), 128'(4'hF));
      chk("st_addr", 128'(data_sram_addr), 128'(32'h1008));
      chk("st_wdata", 128'(data_sram_wdata), 128'(32'hDEAD_BEEF));
      cycle(0, '0, 1);
      chk("st_one_shot", 128'(data_sram_en), 128'(0));

      // ld.w held by MEM for three cycles
      cycle(1, mk_bus(1, 0, 1, 5'd5, 1, 0, ALU_ADD, 32'd4, 32'd0, 32'h2000, 32'h1C00_0008), 0);
      snap = es_to_ms_bus;
      for (int i = 0; i < 3; i++) begin
         chk("ld_stall_en", 128'(data_sram_en), 128'(0));
         chk("ld_stall_allowin", 128'(es_allowin), 128'(0));
         chk("ld_stall_is_load", 128'(es_fwd_is_load), 128'(1));
         chk("ld_stall_bus", 128'(es_to_ms_bus), 128'(snap));
         if (i < 2) cycle(0, '0, 0);
      end
      ms_allowin = 1'b1;
      #1;
      chk("ld_release_en", 128'(data_sram_en), 128'(1));
      chk("ld_release_addr", 128'(data_sram_addr), 128'(32'h2004));
      cycle(0, '0, 1);
      chk("ld_after_en", 128'(data_sram_en), 128'(0));

      // bl link value, then dest=0 variant
      cycle(1, mk_bus(0, 0, 1, 5'd1, 1, 1, ALU_ADD, 32'd4, 32'd0, 32'd0, 32'h1C00_0010), 1);
      chk("bl_result", 128'(es_to_ms_bus[63:32]), 128'(32'h1C00_0014));
      chk("bl_fwd_we", 128'(es_fwd_we), 128'(1));
      chk("bl_fwd_dest", 128'(es_fwd_dest), 128'(1));
      cycle(1, mk_bus(0, 0, 1, 5'd0, 1, 1, ALU_ADD, 32'd4, 32'd0, 32'd0, 32'h1C00_0010), 1);
      chk("bl_r0_fwd_we", 128'(es_fwd_we), 128'(0));

      // three back-to-back ALU ops, no bubbles
      for (int i = 0; i < 3; i++) begin
         cycle(1, mk_bus(0, 0, 1, 5'(i + 10), 0, 0, 4'(i + 3), 0, 32'h0F0F_00FF, 32'h00FF_F0F0,
                         32'h1C00_0100 + 32'(4 * i)), 1);
         chk("b2b_valid", 128'(es_to_ms_valid), 128'(1));
         chk("b2b_pc", 128'(es_to_ms_bus[31:0]), 128'(32'h1C00_0100 + 32'(4 * i)));
      end
      cycle(0, '0, 1);

      // reset while an instruction is in flight
      cycle(1, mk_bus(0, 1, 0, 5'd0, 1, 0, ALU_ADD, 32'd0, 32'd1, 32'h3000, 32'h1C00_0200), 1);
      do_reset(1);

      // randomized traffic with random MEM back-pressure
      repeat (400) begin
         cycle(($urandom % 4) != 0, rand_bus(), ($urandom % 3) != 0);
      end

      for (int i = 0; i < 10 && exp_q.size() != 0; i++) cycle(0, '0, 1);
      chk("drain_empty", 128'(exp_q.size()), 128'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
